// File: rtl/fp_mult_pipe_if.sv
// fp_mult_pipe_if
// Stream bundle for the pipelined floating-point multiplier.
//   in_valid / in_ready / in_a / in_b      : operand stream (producer -> multiplier)
//   out_valid / out_ready / out_p / out_flags : result stream (multiplier -> consumer)
// Word layout of in_a, in_b, out_p: {sign, exp[EXP_W-1:0], frac[FRAC_W-1:0]}.
// out_flags: {invalid, overflow, underflow, inexact}.
// Handshake: a word moves across a stream exactly on a rising edge where
// valid and ready are both 1; while valid is high and ready is low the
// producer holds the word unchanged.
// Modports: master = the side that feeds operands and consumes results,
//           slave  = the multiplier.
interface fp_mult_pipe_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    localparam int W = 1 + EXP_W + FRAC_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_p;
    logic [3:0]   out_flags;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, out_flags
    );
endinterface

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe
// Pipelined IEEE-754-style multiplier, round-to-nearest-even, subnormals
// flushed to signed zero, full NaN/inf/zero handling.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset; clears every valid bit and the outputs
//   bus  : fp_mult_pipe_if.slave (operand stream in, product stream out)
// Pipeline: operand capture register, then S1 (decode/classify/sign/exponent
// sum), S2 (mantissa multiply), S3 (normalise/round/pack into the output
// registers). Operands accepted on edge k are presented after edge k+3.
// A stalled output freezes the whole pipe, bubbles included, so in_ready is
// simply the inverse of the output stall.
module fp_mult_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input logic            clk,
    input logic            rst,
    fp_mult_pipe_if.slave  bus
);
    localparam int W   = 1 + EXP_W + FRAC_W;
    localparam int MW  = FRAC_W + 1;
    localparam int PW  = 2 * MW;
    localparam int EW2 = EXP_W + 2;

    localparam logic [EXP_W-1:0]      EXP_ONES  = '1;
    localparam logic [EXP_W-1:0]      EXP_ZERO  = '0;
    localparam logic [FRAC_W-1:0]     FRAC_ZERO = '0;
    localparam logic [FRAC_W-1:0]     QNAN_FRAC = FRAC_W'(1) << (FRAC_W - 1);
    localparam logic signed [EW2-1:0] BIAS      = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] E_OVF     = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] E_ZERO    = '0;

    // Operand class, already resolved by special-value precedence in S1.
    localparam logic [1:0] CLS_FIN  = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    // Operand capture
    logic                  v0_q, v0_d;
    logic [W-1:0]          a_q, a_d, b_q, b_d;
    // S1
    logic                  v1_q, v1_d;
    logic                  sign1_q, sign1_d;
    logic [1:0]            cls1_q, cls1_d;
    logic                  inv1_q, inv1_d;
    logic signed [EW2-1:0] exp1_q, exp1_d;
    logic [MW-1:0]         ma1_q, ma1_d, mb1_q, mb1_d;
    // S2
    logic                  v2_q, v2_d;
    logic                  sign2_q, sign2_d;
    logic [1:0]            cls2_q, cls2_d;
    logic                  inv2_q, inv2_d;
    logic signed [EW2-1:0] exp2_q, exp2_d;
    logic [PW-1:0]         prod2_q, prod2_d;
    // S3 / outputs
    logic                  out_valid_q, out_valid_d;
    logic [W-1:0]          out_p_q, out_p_d;
    logic [3:0]            out_flags_q, out_flags_d;

    logic stall;
    logic advance;

    assign stall         = out_valid_q & ~bus.out_ready;
    assign advance       = ~stall;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign bus.out_flags = out_flags_q;

    // ---------------- S1 decode ----------------
    logic                  sa, sb;
    logic [EXP_W-1:0]      ea, eb;
    logic [FRAC_W-1:0]     fa, fb;
    logic                  a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, inf_zero;
    logic [1:0]            cls_s1;
    logic signed [EW2-1:0] exp_sum;

    always_comb begin
        sa = a_q[W-1];
        ea = a_q[W-2 -: EXP_W];
        fa = a_q[FRAC_W-1:0];
        sb = b_q[W-1];
        eb = b_q[W-2 -: EXP_W];
        fb = b_q[FRAC_W-1:0];

        // exp==0 covers both true zero and flushed subnormals.
        a_zero = (ea == EXP_ZERO);
        a_inf  = (ea == EXP_ONES) && (fa == FRAC_ZERO);
        a_nan  = (ea == EXP_ONES) && (fa != FRAC_ZERO);
        b_zero = (eb == EXP_ZERO);
        b_inf  = (eb == EXP_ONES) && (fb == FRAC_ZERO);
        b_nan  = (eb == EXP_ONES) && (fb != FRAC_ZERO);
        inf_zero = (a_inf & b_zero) | (a_zero & b_inf);

        if (a_nan | b_nan | inf_zero)  cls_s1 = CLS_NAN;
        else if (a_inf | b_inf)        cls_s1 = CLS_INF;
        else if (a_zero | b_zero)      cls_s1 = CLS_ZERO;
        else                           cls_s1 = CLS_FIN;

        // Widened signed so that both overflow and underflow stay visible.
        exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    end

    // ---------------- S3 normalise / round / pack ----------------
    logic                  lead;
    logic [PW-2:0]         norm;
    logic [FRAC_W-1:0]     frac, frac_r;
    logic                  guard, sticky, round_up, carry;
    logic signed [EW2-1:0] e_fin;
    logic [W-1:0]          p_s3;
    logic [3:0]            flags_s3;

    always_comb begin
        lead = prod2_q[PW-1];
        // Drop the leading one so the fraction always starts at the top bit.
        norm = lead ? prod2_q[PW-2:0] : {prod2_q[PW-3:0], 1'b0};
        frac   = norm[PW-2 -: FRAC_W];
        guard  = norm[PW-2-FRAC_W];
        sticky = |norm[PW-3-FRAC_W:0];
        round_up = guard & (sticky | frac[0]);
        {carry, frac_r} = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
        e_fin = exp2_q + $signed({{(EW2-1){1'b0}}, lead})
                       + $signed({{(EW2-1){1'b0}}, carry});

        p_s3     = {sign2_q, EXP_ZERO, FRAC_ZERO};
        flags_s3 = 4'b0000;
        case (cls2_q)
            CLS_NAN: begin
                p_s3     = {1'b0, EXP_ONES, QNAN_FRAC};
                flags_s3 = {inv2_q, 3'b000};
            end
            CLS_INF: begin
                p_s3 = {sign2_q, EXP_ONES, FRAC_ZERO};
            end
            CLS_ZERO: begin
                p_s3 = {sign2_q, EXP_ZERO, FRAC_ZERO};
            end
            default: begin
                if (e_fin >= E_OVF) begin
                    p_s3     = {sign2_q, EXP_ONES, FRAC_ZERO};
                    flags_s3 = 4'b0101;
                end else if (e_fin <= E_ZERO) begin
                    p_s3     = {sign2_q, EXP_ZERO, FRAC_ZERO};
                    flags_s3 = 4'b0011;
                end else begin
                    p_s3     = {sign2_q, e_fin[EXP_W-1:0], frac_r};
                    flags_s3 = {3'b000, guard | sticky};
                end
            end
        endcase
    end

    // ---------------- next state ----------------
    always_comb begin
        v0_d        = v0_q;
        a_d         = a_q;
        b_d         = b_q;
        v1_d        = v1_q;
        sign1_d     = sign1_q;
        cls1_d      = cls1_q;
        inv1_d      = inv1_q;
        exp1_d      = exp1_q;
        ma1_d       = ma1_q;
        mb1_d       = mb1_q;
        v2_d        = v2_q;
        sign2_d     = sign2_q;
        cls2_d      = cls2_q;
        inv2_d      = inv2_q;
        exp2_d      = exp2_q;
        prod2_d     = prod2_q;
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
        out_flags_d = out_flags_q;

        if (advance) begin
            // in_ready is 1 whenever we advance, so in_valid alone marks a transfer.
            v0_d        = bus.in_valid;
            a_d         = bus.in_a;
            b_d         = bus.in_b;

            v1_d        = v0_q;
            sign1_d     = sa ^ sb;
            cls1_d      = cls_s1;
            inv1_d      = inf_zero;
            exp1_d      = exp_sum;
            ma1_d       = {1'b1, fa};
            mb1_d       = {1'b1, fb};

            v2_d        = v1_q;
            sign2_d     = sign1_q;
            cls2_d      = cls1_q;
            inv2_d      = inv1_q;
            exp2_d      = exp1_q;
            prod2_d     = PW'(ma1_q) * PW'(mb1_q);

            out_valid_d = v2_q;
            out_p_d     = p_s3;
            out_flags_d = flags_s3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            v1_q        <= 1'b0;
            sign1_q     <= 1'b0;
            cls1_q      <= CLS_ZERO;
            inv1_q      <= 1'b0;
            exp1_q      <= '0;
            ma1_q       <= '0;
            mb1_q       <= '0;
            v2_q        <= 1'b0;
            sign2_q     <= 1'b0;
            cls2_q      <= CLS_ZERO;
            inv2_q      <= 1'b0;
            exp2_q      <= '0;
            prod2_q     <= '0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_flags_q <= 4'b0000;
        end else begin
            v0_q        <= v0_d;
            a_q         <= a_d;
            b_q         <= b_d;
            v1_q        <= v1_d;
            sign1_q     <= sign1_d;
            cls1_q      <= cls1_d;
            inv1_q      <= inv1_d;
            exp1_q      <= exp1_d;
            ma1_q       <= ma1_d;
            mb1_q       <= mb1_d;
            v2_q        <= v2_d;
            sign2_q     <= sign2_d;
            cls2_q      <= cls2_d;
            inv2_q      <= inv2_d;
            exp2_q      <= exp2_d;
            prod2_q     <= prod2_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
            out_flags_q <= out_flags_d;
        end
    end
endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Parametrised, pipelined IEEE-754-style floating-point multiplier with a valid/ready stream interface, round-to-nearest-even and full special-value handling. It is the streaming successor to the team's single-cycle combinational FP32 multiplier and sits in the datapath wherever a throughput-of-one FP product is needed under backpressure. Default parameters give binary32.

## Interface
- `EXP_W`, default 8: exponent field width (≥3); bias = 2^(EXP_W-1)-1
- `FRAC_W`, default 23: stored fraction width (≥2); word width W = 1+EXP_W+FRAC_W
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `in_valid`  in  1  operand pair present
- `in_ready`  out  1  block accepts operands this cycle
- `in_a`, `in_b`  in  W  operands {sign, exp, frac}
- `out_valid`  out  1  result present
- `out_ready`  in  1  downstream accepts result
- `out_p`  out  W  product
- `out_flags`  out  4  {invalid, overflow, underflow, inexact}, aligned with `out_p`

## Operation
- Operand decode: exp==0 means zero; subnormals are flushed to zero, including the sign. exp all-ones with frac==0 means inf; exp all-ones with frac≠0 means NaN.
- Sign: s = sa ^ sb for every non-NaN result.
- Special precedence, first match wins:
  1. Either operand NaN, or inf×zero: canonical qNaN {0, all-ones, 1, zeros}. invalid=1 only for inf×zero.
  2. Either operand inf: signed inf, no flags.
  3. Either operand zero: signed zero, no flags.
- Finite path:
  - Mantissas ma={1,fa}, mb={1,fb}. Product P is 2·FRAC_W+2 bits wide.
  - n = P[MSB]. Normalised fraction F is the FRAC_W bits below the leading one. Guard is the next bit; sticky is the OR of all remaining bits.
  - Round to nearest even: increment F when guard & (sticky | F[0]). On carry-out, F=0 and the exponent gains 1.
  - Unbiased sum computed in EXP_W+2-bit signed width: E = ea + eb − bias + n + carry.
  - E ≥ 2^EXP_W−1: signed inf, overflow=1, inexact=1.
  - E ≤ 0: signed zero, underflow=1, inexact=1 (no subnormal output).
  - Otherwise {s, E[EXP_W-1:0], F}, with inexact = guard|sticky.
- Pipeline has 3 register stages:
  - S1: decode, classify, sign, exponent sum.
  - S2: mantissa multiply.
  - S3: normalise, round, pack. S3 drives `out_*` directly from registers.
- Flow control:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, purely combinational from registers and out_ready.
  - On stall, every stage holds, including bubbles.
  - Transfer in occurs on in_valid & in_ready. Transfer out occurs on out_valid & out_ready.
- Reset:
  - out_valid=0, out_p=0, out_flags=0, and all stage valid bits 0.
  - Any in-flight operations are discarded; there is no partial output.
  - Operands presented during the reset cycle are dropped.

## Timing
- Latency is 3 cycles. Operands accepted at edge k produce out_valid=1 after edge k+3 if there is no stall.
- Throughput is one result per cycle while out_ready=1.
- out_p and out_flags stay stable while out_valid & ~out_ready.
- Results emerge in acceptance order. No result is ever dropped or duplicated.
- Simultaneous out transfer and in transfer in the same cycle is legal and is the steady state.
- After deasserting rst, in_ready=1 on the first cycle.

## Test plan
- Basic (default params): 0x3FC00000×0x40000000 → 0x40400000, flags 0. 0xC0000000×0x40400000 → 0xC0C00000. Each appears exactly 3 cycles after acceptance.
- Rounding: 0x3F800001×0x3F800001 → 0x3F800002, inexact=1.
- Boundaries:
  - 0x7F000000×0x40000000 → 0x7F800000, overflow=1, inexact=1.
  - 0x00800000×0x3F000000 → 0x00000000, underflow=1, inexact=1.
  - 0x80000000×0x3F800000 → 0x80000000, flags 0.
- Specials:
  - 0x7F800000×0x00000000 → 0x7FC00000, invalid=1.
  - 0x7FC00001×0x3F800000 → 0x7FC00000, invalid=0.
  - 0xFF800000×0x40000000 → 0xFF800000.
- Backpressure: stream 10 random operand pairs with out_ready toggling randomly. Results must match the reference model in order with no loss. in_ready must be 0 exactly when out_valid & ~out_ready. Outputs must stay stable during stalls.
- Reset and parameters:
  - Assert rst with 3 ops in flight: no out_valid afterwards until new operands are sent.
  - Rerun all checks with EXP_W=5, FRAC_W=10 (binary16): 0x3E00×0x4000 → 0x4200.
